// File: rtl/ref_clk_fwd_tx_pkg.sv
// Shared types and constants for the forwarded reference-clock transmitter.
package ref_clk_fwd_tx_pkg;

  localparam int unsigned DIV_W_DEF = 8;

  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/ref_clk_fwd_tx_if.sv
// Control, configuration and pad-side signals of the forwarded clock transmitter.
interface ref_clk_fwd_tx_if
  import ref_clk_fwd_tx_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CNT_W = 16
);
  logic             EN;
  logic [DIV_W-1:0] CFG_DIV;
  logic             CFG_VALID;
  logic             CFG_READY;
  logic             CLK_FWD_P;
  logic             CLK_FWD_N;
  logic             RUNNING;
  logic [CNT_W-1:0] EDGE_CNT;

  modport master (
    output EN, CFG_DIV, CFG_VALID,
    input  CFG_READY, CLK_FWD_P, CLK_FWD_N, RUNNING, EDGE_CNT
  );

  modport slave (
    input  EN, CFG_DIV, CFG_VALID,
    output CFG_READY, CLK_FWD_P, CLK_FWD_N, RUNNING, EDGE_CNT
  );
endinterface

// File: rtl/ref_clk_div_core.sv
// Half-period divider: phase counter, phase flop pair and the active half-period H.
module ref_clk_div_core
  import ref_clk_fwd_tx_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic             load_div,
  input  logic [DIV_W-1:0] div_in,
  output logic             boundary,
  output logic             rise,
  output logic             clk_p,
  output logic             clk_n
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] h;
  logic [DIV_W-1:0] h_last;
  logic [DIV_W-1:0] h_new;
  logic             cnt_end;

  assign h_last   = h - DIV_W'(1);
  assign cnt_end  = (cnt == h_last);
  assign h_new    = (div_in == '0) ? DIV_W'(1) : div_in;
  assign boundary = (clk_p == PH_LOW) && cnt_end;
  // A start from IDLE behaves like a period boundary so the first pulse is full width.
  assign rise     = run && (clk_p == PH_LOW) && (start || cnt_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p <= PH_LOW;
      clk_n <= 1'b1;
      cnt   <= '0;
      h     <= DIV_W'(DIV_RST);
    end else begin
      if (load_div) h <= h_new;
      if (!run) begin
        clk_p <= PH_LOW;
        clk_n <= 1'b1;
        cnt   <= '0;
      end else if (rise) begin
        clk_p <= PH_HIGH;
        clk_n <= 1'b0;
        cnt   <= '0;
      end else if (cnt_end) begin
        clk_p <= PH_LOW;
        clk_n <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/ref_clk_fwd_tx.sv
// Glitch-free forwarded reference clock: run/stop FSM, divider config handshake, edge counter.
module ref_clk_fwd_tx
  import ref_clk_fwd_tx_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  ref_clk_fwd_tx_if.slave      bus
);

  state_t           state;
  state_t           state_next;
  logic             start;
  logic             run;
  logic             boundary;
  logic             rise;
  logic             load_div;
  logic             pend_valid;
  logic [DIV_W-1:0] pend;
  logic [CNT_W-1:0] edge_cnt;
  logic             clk_p;
  logic             clk_n;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: if (bus.EN) begin
        state_next = RUN;
        start      = 1'b1;
      end
      RUN: if (!bus.EN) state_next = STOPPING;
      STOPPING: begin
        if (bus.EN)        state_next = RUN;
        else if (boundary) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The divider keeps counting whenever the FSM is not about to park in IDLE.
  assign run = (state_next != IDLE);

  // pend_valid is registered, so a value accepted on a boundary waits for the next one.
  assign load_div = pend_valid && ((state == IDLE) || boundary);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (load_div) begin
      pend_valid <= 1'b0;
    end else if (bus.CFG_VALID && !pend_valid) begin
      pend_valid <= 1'b1;
      pend       <= bus.CFG_DIV;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)   edge_cnt <= '0;
    else if (rise) edge_cnt <= edge_cnt + CNT_W'(1);
  end

  ref_clk_div_core #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RESETN),
    .run      (run),
    .start    (start),
    .load_div (load_div),
    .div_in   (pend),
    .boundary (boundary),
    .rise     (rise),
    .clk_p    (clk_p),
    .clk_n    (clk_n)
  );

  assign bus.CFG_READY = !pend_valid;
  assign bus.CLK_FWD_P = clk_p;
  assign bus.CLK_FWD_N = clk_n;
  assign bus.RUNNING   = (state != IDLE);
  assign bus.EDGE_CNT  = edge_cnt;

endmodule

// File: tb/tb_ref_clk_fwd_tx.sv
// Directed bench for ref_clk_fwd_tx: start/stop, re-enable, divider changes, wrap and reset.
module tb_ref_clk_fwd_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  ref_clk_fwd_tx_if #(.DIV_W(8), .CNT_W(16)) bus ();
  ref_clk_fwd_tx_if #(.DIV_W(8), .CNT_W(4))  bus4 ();

  ref_clk_fwd_tx #(.DIV_W(8), .DIV_RST(4), .CNT_W(16)) dut (
    .CLK(clk), .RESETN(rst_n), .bus(bus)
  );

  ref_clk_fwd_tx #(.DIV_W(8), .DIV_RST(1), .CNT_W(4)) dut4 (
    .CLK(clk), .RESETN(rst_n), .bus(bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.EN = 1'b0;  bus.CFG_DIV = '0;  bus.CFG_VALID = 1'b0;
    bus4.EN = 1'b0; bus4.CFG_DIV = '0; bus4.CFG_VALID = 1'b0;
    tick(); tick();
    tests_run++; if (bus.CLK_FWD_P !== 1'b0) begin tests_failed++; $display("FAIL reset_p: got %b expected 0", bus.CLK_FWD_P); end
    tests_run++; if (bus.CLK_FWD_N !== 1'b1) begin tests_failed++; $display("FAIL reset_n: got %b expected 1", bus.CLK_FWD_N); end
    tests_run++; if (bus.RUNNING !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b expected 0", bus.RUNNING); end
    tests_run++; if (bus.EDGE_CNT !== 16'd0) begin tests_failed++; $display("FAIL reset_edge_cnt: got %0d expected 0", bus.EDGE_CNT); end
    tests_run++; if (bus.CFG_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.CFG_READY); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (bus.CLK_FWD_P !== 1'b0 || bus.RUNNING !== 1'b0) begin
        tests_failed++; $display("FAIL idle_hold[%0d]: got p=%b running=%b expected p=0 running=0", i, bus.CLK_FWD_P, bus.RUNNING);
      end
    end
  endtask

  // EN high -> P rises next cycle, 4 high / 4 low, EDGE_CNT 3 after 24 cycles.
  task automatic test_start();
    logic exp_p;
    bus.EN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      exp_p = ((i % 8) < 4);
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p || bus.CLK_FWD_N !== ~exp_p) begin
        tests_failed++; $display("FAIL start_wave[%0d]: got p=%b n=%b expected p=%b n=%b", i, bus.CLK_FWD_P, bus.CLK_FWD_N, exp_p, ~exp_p);
      end
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd3) begin tests_failed++; $display("FAIL start_edge_cnt: got %0d expected 3", bus.EDGE_CNT); end
  endtask

  // EN dropped 2 cycles into a high phase: 2 more high, 4 low, then IDLE.
  task automatic test_stop();
    logic exp_p, exp_run;
    tick(); tick();
    bus.EN = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_p   = (i < 2);
      exp_run = (i < 6);
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p || bus.RUNNING !== exp_run) begin
        tests_failed++; $display("FAIL stop_wave[%0d]: got p=%b running=%b expected p=%b running=%b", i, bus.CLK_FWD_P, bus.RUNNING, exp_p, exp_run);
      end
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd4) begin tests_failed++; $display("FAIL stop_edge_cnt: got %0d expected 4", bus.EDGE_CNT); end
  endtask

  // EN drops for 3 cycles within one period: waveform unchanged, RUNNING stays high.
  task automatic test_reenable();
    logic exp_p;
    bus.EN = 1'b1;
    for (int j = 0; j < 24; j++) begin
      tick();
      exp_p = ((j % 8) < 4);
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p || bus.RUNNING !== 1'b1) begin
        tests_failed++; $display("FAIL reenable_wave[%0d]: got p=%b running=%b expected p=%b running=1", j, bus.CLK_FWD_P, bus.RUNNING, exp_p);
      end
      if (j == 1) bus.EN = 1'b0;
      if (j == 4) bus.EN = 1'b1;
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd7) begin tests_failed++; $display("FAIL reenable_edge_cnt: got %0d expected 7", bus.EDGE_CNT); end
  endtask

  // CFG_DIV=2 mid high phase, then a back-pressured CFG_DIV=3; each applies at a boundary.
  task automatic test_cfg_change();
    bit exp_p   [16] = '{1,1,0,0,0,0,1,1,0,0,1,1,1,0,0,0};
    bit exp_rdy [16] = '{0,0,0,0,0,0,1,0,0,0,1,1,1,1,1,1};
    tick(); tick();
    bus.CFG_DIV = 8'd2; bus.CFG_VALID = 1'b1;
    for (int k = 2; k < 18; k++) begin
      tick();
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p[k-2] || bus.CFG_READY !== exp_rdy[k-2]) begin
        tests_failed++; $display("FAIL cfg_wave[%0d]: got p=%b ready=%b expected p=%b ready=%b", k, bus.CLK_FWD_P, bus.CFG_READY, exp_p[k-2], exp_rdy[k-2]);
      end
      if (k == 2)  bus.CFG_DIV = 8'd3;
      if (k == 9)  bus.CFG_VALID = 1'b0;
      if (k == 16) bus.EN = 1'b0;
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd10) begin tests_failed++; $display("FAIL cfg_edge_cnt: got %0d expected 10", bus.EDGE_CNT); end
    tick();
    tests_run++;
    if (bus.RUNNING !== 1'b0 || bus.CLK_FWD_P !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_stop: got running=%b p=%b expected running=0 p=0", bus.RUNNING, bus.CLK_FWD_P);
    end
  endtask

  // CFG_DIV=0 in IDLE becomes H=1: P toggles every cycle.
  task automatic test_idle_div0();
    logic exp_p;
    bus.CFG_DIV = 8'd0; bus.CFG_VALID = 1'b1;
    tick();
    bus.CFG_VALID = 1'b0;
    tests_run++; if (bus.CFG_READY !== 1'b0) begin tests_failed++; $display("FAIL div0_ready_low: got %b expected 0", bus.CFG_READY); end
    tick();
    tests_run++; if (bus.CFG_READY !== 1'b1) begin tests_failed++; $display("FAIL div0_ready_high: got %b expected 1", bus.CFG_READY); end
    bus.EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_p = ((i % 2) == 0);
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p || bus.CLK_FWD_N !== ~exp_p) begin
        tests_failed++; $display("FAIL div0_wave[%0d]: got p=%b n=%b expected p=%b n=%b", i, bus.CLK_FWD_P, bus.CLK_FWD_N, exp_p, ~exp_p);
      end
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd14) begin tests_failed++; $display("FAIL div0_edge_cnt: got %0d expected 14", bus.EDGE_CNT); end
    bus.EN = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (bus.RUNNING !== 1'b0 || bus.CLK_FWD_P !== 1'b0 || bus.EDGE_CNT !== 16'd15) begin
      tests_failed++; $display("FAIL div0_stop: got running=%b p=%b edge_cnt=%0d expected running=0 p=0 edge_cnt=15", bus.RUNNING, bus.CLK_FWD_P, bus.EDGE_CNT);
    end
  endtask

  // 4-bit EDGE_CNT wraps after 16 rises; reset mid high phase clears everything at once.
  task automatic test_wrap_and_reset();
    logic exp_p;
    bus4.EN = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      tick();
      if (t == 30) begin
        tests_run++; if (bus4.EDGE_CNT !== 4'd15) begin tests_failed++; $display("FAIL wrap_pre: got %0d expected 15", bus4.EDGE_CNT); end
      end
      if (t == 31) begin
        tests_run++; if (bus4.EDGE_CNT !== 4'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d expected 0", bus4.EDGE_CNT); end
      end
      if (t == 34) begin
        tests_run++; if (bus4.EDGE_CNT !== 4'd1) begin tests_failed++; $display("FAIL wrap_17: got %0d expected 1", bus4.EDGE_CNT); end
      end
    end
    bus4.EN = 1'b0;
    bus.CFG_DIV = 8'd2; bus.CFG_VALID = 1'b1;
    tick();
    bus.CFG_VALID = 1'b0;
    tick();
    bus.EN = 1'b1;
    tick();
    tests_run++; if (bus.CLK_FWD_P !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_high: got %b expected 1", bus.CLK_FWD_P); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.CLK_FWD_P !== 1'b0 || bus.CLK_FWD_N !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset_pn: got p=%b n=%b expected p=0 n=1", bus.CLK_FWD_P, bus.CLK_FWD_N);
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd0) begin tests_failed++; $display("FAIL async_reset_cnt: got %0d expected 0", bus.EDGE_CNT); end
    tests_run++; if (bus4.EDGE_CNT !== 4'd0) begin tests_failed++; $display("FAIL async_reset_cnt4: got %0d expected 0", bus4.EDGE_CNT); end
    tests_run++; if (bus.RUNNING !== 1'b0) begin tests_failed++; $display("FAIL async_reset_running: got %b expected 0", bus.RUNNING); end
    rst_n = 1'b1;
    // Divider must be back at DIV_RST=4 after reset.
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_p = (i < 4);
      tests_run++;
      if (bus.CLK_FWD_P !== exp_p) begin
        tests_failed++; $display("FAIL post_reset_wave[%0d]: got %b expected %b", i, bus.CLK_FWD_P, exp_p);
      end
    end
    tests_run++; if (bus.EDGE_CNT !== 16'd1) begin tests_failed++; $display("FAIL post_reset_cnt: got %0d expected 1", bus.EDGE_CNT); end
    bus.EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_reenable();
    test_cfg_change();
    test_idle_div0();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
